// File: rtl/gm_pkg.sv
// Gold Miner shared playfield constants and hook state encoding.
// Imported by the swing generator, drawcon and hook launcher.
package gm_pkg;

    localparam int GM_X_W     = 11;
    localparam int GM_Y_W     = 10;
    localparam int GM_PIVOT_X = 625;
    localparam int GM_PIVOT_Y = 11;
    localparam int GM_X_MIN   = 10;
    localparam int GM_X_MAX   = 1269;
    localparam int GM_Y_MIN   = 10;
    localparam int GM_Y_MAX   = 789;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXTEND,
        ST_RETRACT,
        ST_DONE
    } hook_state_t;

endpackage

// File: rtl/line_stepper.sv
// Bresenham-style line walker: holds hook position, error term and length.
// Forward and reverse steps are exact inverses, so retract retraces the pixels.
module line_stepper
    import gm_pkg::*;
#(
    parameter int PIVOT_X = GM_PIVOT_X,
    parameter int PIVOT_Y = GM_PIVOT_Y
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step_fwd,
    input  logic                step_rev,
    input  logic [GM_X_W-1:0]   swing_x,
    input  logic [GM_Y_W-1:0]   swing_y,
    input  logic [11:0]         dmaj,
    input  logic [11:0]         dmin,
    input  logic                x_major,
    input  logic                neg_x,
    input  logic                neg_y,
    output logic [GM_X_W-1:0]   pos_x,
    output logic [GM_Y_W-1:0]   pos_y,
    output logic [GM_X_W-1:0]   nxt_x,
    output logic [GM_Y_W-1:0]   nxt_y,
    output logic [10:0]         len
);

    logic [11:0]       err;
    logic [12:0]       sum;
    logic              carry;
    logic              borrow;
    logic [11:0]       err_f;
    logic [11:0]       err_r;
    logic              mvx_f, mvy_f, mvx_r, mvy_r;
    logic [GM_X_W-1:0] prv_x;
    logic [GM_Y_W-1:0] prv_y;

    // Candidate forward and reverse positions and error terms.
    always_comb begin
        sum    = {1'b0, err} + {1'b0, dmin};
        carry  = sum >= {1'b0, dmaj};
        err_f  = carry ? 12'(sum - {1'b0, dmaj}) : sum[11:0];
        borrow = err < dmin;
        err_r  = borrow ? (err + dmaj - dmin) : (err - dmin);
        mvx_f  = x_major | carry;
        mvy_f  = ~x_major | carry;
        mvx_r  = x_major | borrow;
        mvy_r  = ~x_major | borrow;
        nxt_x  = neg_x ? pos_x - {10'd0, mvx_f} : pos_x + {10'd0, mvx_f};
        nxt_y  = neg_y ? pos_y - {9'd0, mvy_f}  : pos_y + {9'd0, mvy_f};
        prv_x  = neg_x ? pos_x + {10'd0, mvx_r} : pos_x - {10'd0, mvx_r};
        prv_y  = neg_y ? pos_y + {9'd0, mvy_r}  : pos_y - {9'd0, mvy_r};
    end

    // Position/error/length register: track swing, or take one step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_x <= GM_X_W'(PIVOT_X);
            pos_y <= GM_Y_W'(PIVOT_Y);
            err   <= '0;
            len   <= '0;
        end else if (load) begin
            pos_x <= swing_x;
            pos_y <= swing_y;
            err   <= '0;
            len   <= '0;
        end else if (step_fwd) begin
            pos_x <= nxt_x;
            pos_y <= nxt_y;
            err   <= err_f;
            len   <= len + 11'd1;
        end else if (step_rev) begin
            pos_x <= prv_x;
            pos_y <= prv_y;
            err   <= err_r;
            len   <= len - 11'd1;
        end
    end

endmodule

// File: rtl/hook_launcher.sv
// Hook-shot controller: freezes the swing, extends the hook along the
// pivot-to-tip line in tick-armed bursts, then retraces it back home.
module hook_launcher
    import gm_pkg::*;
#(
    parameter int PIVOT_X   = GM_PIVOT_X,
    parameter int PIVOT_Y   = GM_PIVOT_Y,
    parameter int X_MIN     = GM_X_MIN,
    parameter int X_MAX     = GM_X_MAX,
    parameter int Y_MIN     = GM_Y_MIN,
    parameter int Y_MAX     = GM_Y_MAX,
    parameter int MAX_LEN   = 600,
    parameter int EXT_STEPS = 4,
    parameter int RET_FAST  = 4,
    parameter int RET_SLOW  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        launch,
    input  logic [10:0] swing_x,
    input  logic [9:0]  swing_y,
    input  logic        hit,
    output logic [10:0] hook_x,
    output logic [9:0]  hook_y,
    output logic        swing_hold,
    output logic        busy,
    output logic        done,
    output logic        grabbed
);

    localparam logic [7:0] N_EXT  = 8'(EXT_STEPS);
    localparam logic [7:0] N_FAST = 8'(RET_FAST);
    localparam logic [7:0] N_SLOW = 8'(RET_SLOW);

    hook_state_t state, state_n;
    logic        launch_q;
    logic        rise;
    logic [11:0] dx, ax, dmaj_in, dmin_in, dmaj, dmin;
    logic [10:0] dy, ay;
    logic        xm_in, x_major, neg_x, neg_y;
    logic [7:0]  cnt, cnt_n;
    logic        load, fwd, rev, latch, grab_set;
    logic        out_of_field;
    logic [10:0] len;
    logic [10:0] nxt_x;
    logic [9:0]  nxt_y;

    assign rise = launch & ~launch_q;

    // Launch geometry taken from the live swing tip.
    always_comb begin
        dx      = {1'b0, swing_x} - 12'(PIVOT_X);
        dy      = {1'b0, swing_y} - 11'(PIVOT_Y);
        ax      = dx[11] ? (~dx + 12'd1) : dx;
        ay      = dy[10] ? (~dy + 11'd1) : dy;
        xm_in   = ax >= {1'b0, ay};
        dmaj_in = xm_in ? ax : {1'b0, ay};
        dmin_in = xm_in ? {1'b0, ay} : ax;
    end

    assign out_of_field = (nxt_x < 11'(X_MIN)) || (nxt_x > 11'(X_MAX)) ||
                          (nxt_y < 10'(Y_MIN)) || (nxt_y > 10'(Y_MAX));

    // State, burst counter and edge-detector registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            launch_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            launch_q <= launch;
        end
    end

    // Latched line geometry and shot result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmaj    <= '0;
            dmin    <= '0;
            x_major <= 1'b0;
            neg_x   <= 1'b0;
            neg_y   <= 1'b0;
            grabbed <= 1'b0;
        end else if (latch) begin
            dmaj    <= dmaj_in;
            dmin    <= dmin_in;
            x_major <= xm_in;
            neg_x   <= dx[11];
            neg_y   <= dy[10];
            grabbed <= 1'b0;
        end else if (grab_set) begin
            grabbed <= 1'b1;
        end
    end

    // Next-state, burst control and step strobes.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        load     = 1'b0;
        latch    = 1'b0;
        fwd      = 1'b0;
        rev      = 1'b0;
        grab_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                load  = 1'b1;
                cnt_n = '0;
                if (rise && dmaj_in != 12'd0) begin
                    latch   = 1'b1;
                    state_n = ST_EXTEND;
                end
            end
            ST_EXTEND: begin
                if (hit) begin
                    grab_set = 1'b1;
                    state_n  = ST_RETRACT;
                    cnt_n    = '0;
                end else if (cnt != 8'd0) begin
                    if (out_of_field || len == 11'(MAX_LEN)) begin
                        state_n = ST_RETRACT;
                        cnt_n   = '0;
                    end else begin
                        fwd   = 1'b1;
                        cnt_n = cnt - 8'd1;
                    end
                end else if (tick) begin
                    cnt_n = N_EXT;
                end
            end
            ST_RETRACT: begin
                if (len == 11'd0) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end else if (cnt != 8'd0) begin
                    rev   = 1'b1;
                    cnt_n = cnt - 8'd1;
                end else if (tick) begin
                    cnt_n = grabbed ? N_SLOW : N_FAST;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign swing_hold = state != ST_IDLE;
    assign busy       = (state == ST_EXTEND) || (state == ST_RETRACT);
    assign done       = state == ST_DONE;

    line_stepper #(
        .PIVOT_X (PIVOT_X),
        .PIVOT_Y (PIVOT_Y)
    ) u_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .step_fwd (fwd),
        .step_rev (rev),
        .swing_x  (swing_x),
        .swing_y  (swing_y),
        .dmaj     (dmaj),
        .dmin     (dmin),
        .x_major  (x_major),
        .neg_x    (neg_x),
        .neg_y    (neg_y),
        .pos_x    (hook_x),
        .pos_y    (hook_y),
        .nxt_x    (nxt_x),
        .nxt_y    (nxt_y),
        .len      (len)
    );

endmodule

// File: tb/tb_hook_launcher.sv
// Directed bench for hook_launcher: border, diagonal and grab shots,
// launch/tick rules and mid-shot reset, all against hand-computed values.
module tb_hook_launcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        launch;
    logic [10:0] swing_x;
    logic [9:0]  swing_y;
    logic        hit;
    logic [10:0] hook_x;
    logic [9:0]  hook_y;
    logic        swing_hold;
    logic        busy;
    logic        done;
    logic        grabbed;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int done_x, done_y, done_err;
    int peak_len, peak_x, peak_y;
    int n;

    hook_launcher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .launch     (launch),
        .swing_x    (swing_x),
        .swing_y    (swing_y),
        .hit        (hit),
        .hook_x     (hook_x),
        .hook_y     (hook_y),
        .swing_hold (swing_hold),
        .busy       (busy),
        .done       (done),
        .grabbed    (grabbed)
    );

    always #5 clk = ~clk;

    // Record done pulses and the farthest point of each shot.
    always @(negedge clk) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            done_x   = int'(hook_x);
            done_y   = int'(hook_y);
            done_err = int'(dut.u_step.err);
        end
        if (int'(dut.u_step.len) > peak_len) begin
            peak_len = int'(dut.u_step.len);
            peak_x   = int'(hook_x);
            peak_y   = int'(hook_y);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic fire();
        peak_len = 0;
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
    endtask

    task automatic run_shot(input int budget, output int nt);
        int d0;
        d0 = done_cnt;
        nt = 0;
        while (done_cnt == d0 && nt < budget) begin
            pulse_tick();
            nt = nt + 1;
        end
        chk("shot_done", done_cnt - d0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; launch = 1'b0; hit = 1'b0;
        swing_x = 11'd625; swing_y = 10'd11;
        peak_len = 0; peak_x = 0; peak_y = 0;
        done_x = 0; done_y = 0; done_err = 0;
        cyc(3);
        chk("rst_x", int'(hook_x), 625);
        chk("rst_y", int'(hook_y), 11);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hold", int'(swing_hold), 0);
        chk("rst_grab", int'(grabbed), 0);
        rst_n = 1'b1;
        cyc(1);
        chk("idle_x", int'(hook_x), 625);
        swing_x = 11'd700; swing_y = 10'd50;
        cyc(1);
        chk("follow_x", int'(hook_x), 700);
        chk("follow_y", int'(hook_y), 50);

        // Horizontal shot to the left border; mid-burst tick dropped.
        swing_x = 11'd550; swing_y = 10'd11;
        cyc(1);
        fire();
        chk("h_busy", int'(busy), 1);
        chk("h_hold", int'(swing_hold), 1);
        chk("h_start_x", int'(hook_x), 550);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(2);
        chk("h_mid_x", int'(hook_x), 548);
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(6);
        chk("h_burst_x", int'(hook_x), 546);
        chk("h_burst_y", int'(hook_y), 11);
        run_shot(400, n);
        chk("h_peak_len", peak_len, 540);
        chk("h_peak_x", peak_x, 10);
        chk("h_peak_y", peak_y, 11);
        chk("h_end_x", done_x, 550);
        chk("h_end_y", done_y, 11);
        chk("h_end_err", done_err, 0);
        chk("h_grab", int'(grabbed), 0);
        chk("h_idle", int'(busy), 0);

        // Diagonal shot to the right border.
        swing_x = 11'd678; swing_y = 10'd64;
        cyc(1);
        fire();
        pulse_tick();
        chk("d_first_x", int'(hook_x), 682);
        chk("d_first_y", int'(hook_y), 68);
        run_shot(400, n);
        chk("d_peak_len", peak_len, 591);
        chk("d_peak_x", peak_x, 1269);
        chk("d_peak_y", peak_y, 655);
        chk("d_end_x", done_x, 678);
        chk("d_end_y", done_y, 64);
        chk("d_end_err", done_err, 0);
        chk("d_grab", int'(grabbed), 0);

        // Straight-down shot that grabs after ten ticks.
        swing_x = 11'd625; swing_y = 10'd86;
        cyc(1);
        fire();
        repeat (10) pulse_tick();
        chk("g_pos_x", int'(hook_x), 625);
        chk("g_pos_y", int'(hook_y), 126);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        chk("g_grab", int'(grabbed), 1);
        chk("g_busy", int'(busy), 1);
        chk("g_hold_y", int'(hook_y), 126);
        run_shot(100, n);
        chk("g_ticks", n, 40);
        chk("g_end_x", done_x, 625);
        chk("g_end_y", done_y, 86);
        chk("g_end_grab", int'(grabbed), 1);

        // Launch held high through a whole shot fires once.
        swing_x = 11'd20; swing_y = 10'd11;
        cyc(1);
        launch = 1'b1;
        cyc(1);
        chk("l_grab_clr", int'(grabbed), 0);
        chk("l_busy", int'(busy), 1);
        run_shot(50, n);
        n = done_cnt;
        repeat (5) pulse_tick();
        chk("l_no_relaunch", done_cnt - n, 0);
        chk("l_idle", int'(busy), 0);
        launch = 1'b0;
        cyc(1);

        // Second launch edge during retract is ignored.
        swing_x = 11'd40; swing_y = 10'd11;
        cyc(1);
        fire();
        repeat (2) pulse_tick();
        chk("r_pos_x", int'(hook_x), 32);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        launch = 1'b1;
        cyc(1);
        launch = 1'b0;
        cyc(1);
        chk("r_busy", int'(busy), 1);
        run_shot(30, n);
        chk("r_ticks", n, 8);
        chk("r_end_x", done_x, 40);
        n = done_cnt;
        cyc(20);
        chk("r_no_shot", done_cnt - n, 0);
        chk("r_idle", int'(busy), 0);

        // Launch at the pivot itself does nothing.
        swing_x = 11'd625; swing_y = 10'd11;
        cyc(1);
        fire();
        chk("z_busy", int'(busy), 0);
        chk("z_hold", int'(swing_hold), 0);

        // Reset in the middle of an extension.
        swing_x = 11'd550; swing_y = 10'd11;
        cyc(1);
        fire();
        repeat (3) pulse_tick();
        chk("m_pos_x", int'(hook_x), 538);
        chk("m_busy", int'(busy), 1);
        rst_n = 1'b0;
        cyc(1);
        chk("m_rst_busy", int'(busy), 0);
        chk("m_rst_hold", int'(swing_hold), 0);
        chk("m_rst_x", int'(hook_x), 625);
        chk("m_rst_y", int'(hook_y), 11);
        swing_x = 11'd560; swing_y = 10'd20;
        rst_n = 1'b1;
        cyc(1);
        chk("m_follow_x", int'(hook_x), 560);
        chk("m_follow_y", int'(hook_y), 20);
        chk("m_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hook_launcher.md
# hook_launcher

Hook-shot controller for the Gold Miner playfield. It sits directly downstream of the swinging hook generator. It consumes the swing tip position (`swing_x`, `swing_y`) and the centre button. On a press it freezes the swing and drives the hook tip outward along the pivot→tip line. It then retracts the hook along exactly the same pixels back to the launch point. The resulting hook position feeds the draw controller and the collision logic.

## Interface
- `PIVOT_X`, default 625: swing pivot x.
- `PIVOT_Y`, default 11: swing pivot y.
- `X_MIN`, default 10 / `X_MAX`, default 1269: playfield x border, inclusive.
- `Y_MIN`, default 10 / `Y_MAX`, default 789: playfield y border, inclusive.
- `MAX_LEN`, default 600: maximum extension, in pixel steps.
- `EXT_STEPS`, default 4: pixels per tick while extending.
- `RET_FAST`, default 4: pixels per tick while retracting empty.
- `RET_SLOW`, default 1: pixels per tick while retracting with a grab.
- `clk` in 1: pixel clock (83.46 MHz).
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `tick` in 1: one-cycle frame-rate step enable (60 Hz).
- `launch` in 1: centre button, level input; the block detects the rising edge internally.
- `swing_x` in 11: swing tip x.
- `swing_y` in 10: swing tip y.
- `hit` in 1: collision detector reports that the hook touches an object.
- `hook_x` out 11: hook tip x.
- `hook_y` out 10: hook tip y.
- `swing_hold` out 1: freezes the swing generator; high in every state except IDLE.
- `busy` out 1: high in EXTEND and RETRACT.
- `done` out 1: one-cycle pulse at the end of a shot.
- `grabbed` out 1: result of the last shot; valid from `done` until the next launch.

## Operation
- **States:** IDLE, EXTEND, RETRACT, DONE.
- **IDLE:** `hook_x`/`hook_y` follow `swing_x`/`swing_y` with one cycle of latency.
  - On a `launch` rising edge, latch `dx = swing_x-PIVOT_X` (signed, 12 b) and `dy = swing_y-PIVOT_Y` (signed, 11 b).
  - Set `dmaj = max(|dx|,|dy|)` and `dmin = min(|dx|,|dy|)`. Clear `err` (12 b) and `len` (11 b), clear `grabbed`, then go to EXTEND.
  - If `dmaj == 0`, the launch is ignored.
- **Stepping:** each `tick` arms a burst of N single-pixel steps, one step per clock. Any `tick` that arrives while a burst is still pending is dropped.
- **Forward step:**
  - Major axis moves ±1.
  - `err += dmin`; if `err >= dmaj`, then `err -= dmaj` and the minor axis moves ±1.
  - `len += 1`.
- **Reverse step (exact inverse):**
  - Major axis moves ∓1.
  - If `err < dmin`, then `err += dmaj - dmin` and the minor axis moves ∓1; else `err -= dmin`.
  - `len -= 1`.
- **EXTEND** (N = `EXT_STEPS`):
  - `hit` is sampled every cycle. When `hit = 1`, set `grabbed = 1` and go to RETRACT, discarding the rest of the burst.
  - Otherwise, before each step, if the next position would leave the border or `len == MAX_LEN`, go to RETRACT with `grabbed = 0`.
  - If `hit` and a border condition occur in the same cycle, `hit` wins.
- **RETRACT** (N = `RET_SLOW` if grabbed, else `RET_FAST`):
  - `hit` is ignored.
  - Reverse steps continue until `len == 0`; the burst stops early at zero.
  - Then go to DONE.
- **DONE:** pulse `done` for one cycle, then return to IDLE.
- `launch` is ignored outside IDLE. A press held through a whole shot does not relaunch; a new rising edge is required.

## Timing
- **Reset values:** state IDLE; `hook_x = PIVOT_X`, `hook_y = PIVOT_Y`; `swing_hold`, `busy`, `done`, `grabbed` = 0; `len`, `err` = 0.
- **Reset mid-shot:** `rst_n` low at any point returns the block to reset values on the next edge. The hook follows the swing again one cycle after release.
- **Launch latency:** launch edge → EXTEND and `swing_hold = 1` on the next cycle.
- **Step latency:**
  - Burst step k (k = 1..N) updates the hook position k cycles after `tick`.
  - A `hit` is acted on in the cycle after it is sampled. The position registered in that cycle is final.
- **Retract exactness:** RETRACT always ends at exactly the latched launch position, with `err = 0`.

## Structure
- **Package `gm_pkg`:**
  - Pivot and border constants, shared with the swing generator and drawcon.
  - State enum `hook_state_t`.
  - Coordinate widths: 11 b for x, 10 b for y.
- **Sub-module `line_stepper`:** holds position, `err` and `len`, and performs forward and reverse steps under `step_fwd`/`step_rev` strobes.
- The FSM, burst counter and launch edge detector stay in `hook_launcher`.

## Test plan
- **Reset:** reset, then swing held at (625,11) → hook (625,11); `busy`, `done`, `swing_hold` = 0.
- **Horizontal border shot:** swing (550,11), launch.
  - After the first tick's 4-cycle burst, hook = (546,11).
  - Reaches (10,11) with `len = 540`, then retracts.
  - Ends at (550,11) with `done` pulse and `grabbed = 0`.
- **Diagonal shot:** swing (678,64) (dx = dy = 53).
  - Steps go (+1,+1).
  - Stops at (1269,655), `len = 591`, then returns exactly to (678,64).
- **Grab:** swing (625,86), `hit` raised after 10 ticks at (625,126).
  - `grabbed = 1`.
  - Retracts 1 px per tick over 40 ticks to (625,86), then `done`.
- **Launch and tick rules:**
  - `launch` held high across a whole shot → exactly one shot.
  - A second launch edge during RETRACT → ignored.
  - A tick arriving mid-burst → dropped.
- **Mid-shot reset:** `rst_n` low during EXTEND → IDLE next cycle, `busy = 0`, hook tracks the swing.
